// File: rtl/commit_trace_buffer.sv
// ============================================================================
// Module      : commit_trace_buffer
// Description : Retirement trace capture. Serializes up to four commit events
//               per cycle (WB, STORE, BR, TRAP) into a show-ahead FIFO with a
//               valid/ready record stream. BR capture enabled by
//               `define COMMIT_TRACE_BR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_trace_buffer #(
   parameter int DEPTH  = 16,
   parameter int DROP_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wb_valid,
   input  logic [31:0]       wb_pc,
   input  logic [31:0]       wb_instr,
   input  logic [4:0]        wb_rd,
   input  logic [31:0]       wb_data,
   input  logic              st_valid,
   input  logic [31:0]       st_pc,
   input  logic [31:0]       st_instr,
   input  logic [31:0]       st_addr,
   input  logic [31:0]       st_data,
   input  logic              br_valid,
   input  logic [31:0]       br_pc,
   input  logic [31:0]       br_instr,
   input  logic [31:0]       br_target,
   input  logic              trap_valid,
   input  logic [31:0]       trap_pc,
   input  logic [31:0]       trap_instr,
   output logic              rec_valid,
   input  logic              rec_ready,
   output logic [1:0]        rec_type,
   output logic [31:0]       rec_pc,
   output logic [31:0]       rec_instr,
   output logic [4:0]        rec_rd,
   output logic [31:0]       rec_addr,
   output logic [31:0]       rec_value,
   output logic              halted,
   output logic              overflow,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_CW = c_AW + 1;
   localparam int c_NEV = 4;
   localparam logic [c_CW-1:0] c_DEPTH_CW = c_CW'(DEPTH);
   localparam logic [c_CW-1:0] c_ONE_CW   = c_CW'(1);
   localparam logic [1:0] c_TYPE_REG   = 2'd0;
   localparam logic [1:0] c_TYPE_STORE = 2'd1;
   localparam logic [1:0] c_TYPE_BR    = 2'd2;
   localparam logic [1:0] c_TYPE_TRAP  = 2'd3;

   typedef struct packed {
      logic [1:0]  typ;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  rd;
      logic [31:0] addr;
      logic [31:0] value;
   } rec_t;

   rec_t              r_mem [DEPTH];
   logic [c_AW-1:0]   r_rd_ptr;
   logic [c_AW-1:0]   r_wr_ptr;
   logic [c_CW-1:0]   r_count;
   logic              r_halted;
   logic              r_overflow;
   logic [DROP_W-1:0] r_drop_cnt;

   logic [c_NEV-1:0]  w_ev_valid;
   rec_t              w_ev_rec [c_NEV];
   logic [c_CW-1:0]   w_rank   [c_NEV];
   logic [c_AW-1:0]   w_slot   [c_NEV];
   logic [c_NEV-1:0]  w_write;
   logic [c_CW-1:0]   w_n_ev;
   logic [c_CW-1:0]   w_free;
   logic [c_CW-1:0]   w_n_push;
   logic [c_CW-1:0]   w_n_drop;
   logic              w_pop;
   logic              w_br_valid;
   logic [DROP_W:0]   w_drop_sum;
   rec_t              w_head;

`ifdef COMMIT_TRACE_BR_EN
   assign w_br_valid = br_valid;
`else
   logic w_unused_br;
   assign w_unused_br = ^{br_valid, br_pc, br_instr, br_target};
   assign w_br_valid  = 1'b0;
`endif

   // Slot order is the event index order: WB, STORE, BR, TRAP.
   assign w_ev_valid = r_halted ? '0 : {trap_valid, w_br_valid, st_valid, wb_valid};

   always_comb begin
      for (int i = 0; i < c_NEV; i++) begin
         w_ev_rec[i] = '0;
      end
      w_ev_rec[0].typ   = c_TYPE_REG;
      w_ev_rec[0].pc    = wb_pc;
      w_ev_rec[0].instr = wb_instr;
      w_ev_rec[0].rd    = wb_rd;
      w_ev_rec[0].value = wb_data;
      w_ev_rec[1].typ   = c_TYPE_STORE;
      w_ev_rec[1].pc    = st_pc;
      w_ev_rec[1].instr = st_instr;
      w_ev_rec[1].addr  = st_addr;
      w_ev_rec[1].value = st_data;
`ifdef COMMIT_TRACE_BR_EN
      w_ev_rec[2].typ   = c_TYPE_BR;
      w_ev_rec[2].pc    = br_pc;
      w_ev_rec[2].instr = br_instr;
      w_ev_rec[2].addr  = br_target;
`endif
      w_ev_rec[3].typ   = c_TYPE_TRAP;
      w_ev_rec[3].pc    = trap_pc;
      w_ev_rec[3].instr = trap_instr;
   end

   // Free space is taken before this cycle's pop, so a pop never makes room
   // for pushes in the same cycle.
   assign w_free = c_DEPTH_CW - r_count;

   always_comb begin
      w_n_ev  = '0;
      w_write = '0;
      for (int i = 0; i < c_NEV; i++) begin
         w_rank[i]  = w_n_ev;
         w_slot[i]  = r_wr_ptr + w_n_ev[c_AW-1:0];
         w_write[i] = w_ev_valid[i] && (w_n_ev < w_free);
         if (w_ev_valid[i]) begin
            w_n_ev = w_n_ev + c_ONE_CW;
         end
      end
      w_n_push = (w_n_ev < w_free) ? w_n_ev : w_free;
      w_n_drop = w_n_ev - w_n_push;
   end

   assign w_pop      = rec_valid && rec_ready;
   assign w_drop_sum = {1'b0, r_drop_cnt} + (DROP_W + 1)'(w_n_drop);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_halted   <= 1'b0;
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + w_n_push[c_AW-1:0];
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= r_count + w_n_push - {{(c_CW-1){1'b0}}, w_pop};
         if (w_write[3]) begin
            r_halted <= 1'b1;
         end
         if (w_n_drop != '0) begin
            r_overflow <= 1'b1;
            r_drop_cnt <= w_drop_sum[DROP_W] ? {DROP_W{1'b1}} : w_drop_sum[DROP_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < c_NEV; i++) begin
         if (w_write[i]) begin
            r_mem[w_slot[i]] <= w_ev_rec[i];
         end
      end
   end

   // Storage is not reset; the head is masked so an empty FIFO shows zeros.
   assign w_head    = r_mem[r_rd_ptr];
   assign rec_valid = (r_count != '0);
   assign rec_type  = rec_valid ? w_head.typ   : '0;
   assign rec_pc    = rec_valid ? w_head.pc    : '0;
   assign rec_instr = rec_valid ? w_head.instr : '0;
   assign rec_rd    = rec_valid ? w_head.rd    : '0;
   assign rec_addr  = rec_valid ? w_head.addr  : '0;
   assign rec_value = rec_valid ? w_head.value : '0;
   assign halted    = r_halted;
   assign overflow  = r_overflow;
   assign drop_cnt  = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_commit_trace_buffer.sv
// ============================================================================
// Module      : tb_commit_trace_buffer
// Description : Directed self-checking bench for commit_trace_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_commit_trace_buffer;

`ifdef COMMIT_TRACE_BR_EN
   localparam int c_BR = 1;
`else
   localparam int c_BR = 0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        wb_valid, st_valid, br_valid, trap_valid;
   logic [31:0] wb_pc, wb_instr, wb_data;
   logic [4:0]  wb_rd;
   logic [31:0] st_pc, st_instr, st_addr, st_data;
   logic [31:0] br_pc, br_instr, br_target;
   logic [31:0] trap_pc, trap_instr;
   logic        rec_valid, rec_ready;
   logic [1:0]  rec_type;
   logic [31:0] rec_pc, rec_instr, rec_addr, rec_value;
   logic [4:0]  rec_rd;
   logic        halted, overflow;
   logic [15:0] drop_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_drop = 0;

   always #5 clk = ~clk;

   commit_trace_buffer #(.DEPTH(16), .DROP_W(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr), .wb_rd(wb_rd), .wb_data(wb_data),
      .st_valid(st_valid), .st_pc(st_pc), .st_instr(st_instr), .st_addr(st_addr), .st_data(st_data),
      .br_valid(br_valid), .br_pc(br_pc), .br_instr(br_instr), .br_target(br_target),
      .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_instr(trap_instr),
      .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_type(rec_type),
      .rec_pc(rec_pc), .rec_instr(rec_instr), .rec_rd(rec_rd),
      .rec_addr(rec_addr), .rec_value(rec_value),
      .halted(halted), .overflow(overflow), .drop_cnt(drop_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_events();
      wb_valid = 0; st_valid = 0; br_valid = 0; trap_valid = 0;
   endtask

   task automatic drive_wb(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data);
      wb_valid = 1; wb_pc = pc; wb_instr = 32'h0000_0013 | {20'd0, rd, 7'd0}; wb_rd = rd; wb_data = data;
   endtask

   task automatic drive_st(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] data);
      st_valid = 1; st_pc = pc; st_instr = 32'h0000_2023; st_addr = addr; st_data = data;
   endtask

   task automatic drive_br(input logic [31:0] pc, input logic [31:0] target);
      br_valid = 1; br_pc = pc; br_instr = 32'h0000_0063; br_target = target;
   endtask

   initial begin
      reset_n = 0; rec_ready = 0;
      clear_events();
      wb_pc = 0; wb_instr = 0; wb_rd = 0; wb_data = 0;
      st_pc = 0; st_instr = 0; st_addr = 0; st_data = 0;
      br_pc = 0; br_instr = 0; br_target = 0;
      trap_pc = 0; trap_instr = 0;
      tick(); tick();
      check("reset_valid", rec_valid, 0);
      check("reset_type", rec_type, 0);
      check("reset_pc", rec_pc, 0);
      check("reset_value", rec_value, 0);
      check("reset_halted", halted, 0);
      check("reset_overflow", overflow, 0);
      check("reset_drop", drop_cnt, 0);
      reset_n = 1;
      tick();

      // Single REG event
      rec_ready = 1;
      drive_wb(32'h10, 5'd5, 32'h1234);
      tick();
      clear_events();
      check("reg_valid", rec_valid, 1);
      check("reg_type", rec_type, 0);
      check("reg_pc", rec_pc, 32'h10);
      check("reg_rd", rec_rd, 5);
      check("reg_value", rec_value, 32'h1234);
      check("reg_addr", rec_addr, 0);
      tick();
      check("reg_empty", rec_valid, 0);

      // WB + STORE + BR in one cycle
      drive_wb(32'h20, 5'd1, 32'h55);
      drive_st(32'h24, 32'h100, 32'hAB);
      drive_br(32'h28, 32'h40);
      tick();
      clear_events();
      check("multi0_type", rec_type, 0);
      check("multi0_pc", rec_pc, 32'h20);
      tick();
      check("multi1_valid", rec_valid, 1);
      check("multi1_type", rec_type, 1);
      check("multi1_pc", rec_pc, 32'h24);
      check("multi1_addr", rec_addr, 32'h100);
      check("multi1_value", rec_value, 32'hAB);
      check("multi1_rd", rec_rd, 0);
      tick();
      if (c_BR == 1) begin
         check("multi2_type", rec_type, 2);
         check("multi2_pc", rec_pc, 32'h28);
         check("multi2_addr", rec_addr, 32'h40);
         check("multi2_value", rec_value, 0);
         tick();
      end
      check("multi_empty", rec_valid, 0);

      // Fill to 16 with the consumer stalled, then overflow with wb+st
      rec_ready = 0;
      for (int i = 0; i < 16; i++) begin
         drive_wb(32'h100 + 32'(4 * i), 5'd2, 32'(i));
         tick();
         check("fill_head", rec_pc, 32'h100);
      end
      drive_wb(32'h200, 5'd3, 32'h1);
      drive_st(32'h204, 32'h300, 32'h2);
      tick();
      clear_events();
      exp_drop = 2;
      check("full_drop", drop_cnt, 32'(exp_drop));
      check("full_overflow", overflow, 1);
      check("full_head", rec_pc, 32'h100);

      // Full with a simultaneous pop: every event dropped
      rec_ready = 1;
      drive_wb(32'h300, 5'd4, 32'h3);
      drive_st(32'h304, 32'h310, 32'h4);
      drive_br(32'h308, 32'h500);
      tick();
      rec_ready = 0;
      exp_drop = exp_drop + 2 + c_BR;
      check("fullpop_drop", drop_cnt, 32'(exp_drop));
      check("fullpop_head", rec_pc, 32'h104);

      // Count 15: only WB fits
      drive_wb(32'h400, 5'd6, 32'h5);
      drive_st(32'h404, 32'h410, 32'h6);
      drive_br(32'h408, 32'h600);
      tick();
      clear_events();
      exp_drop = exp_drop + 1 + c_BR;
      check("c15_drop", drop_cnt, 32'(exp_drop));

      // Drain all 16 records
      rec_ready = 1;
      for (int i = 0; i < 16; i++) begin
         check("drain_valid", rec_valid, 1);
         check("drain_pc", rec_pc, (i < 15) ? 32'h104 + 32'(4 * i) : 32'h400);
         tick();
      end
      check("drain_empty", rec_valid, 0);

      // Reset with 7 records queued
      rec_ready = 0;
      for (int i = 0; i < 7; i++) begin
         drive_wb(32'h700 + 32'(4 * i), 5'd7, 32'(i));
         tick();
      end
      clear_events();
      check("pre_rst_valid", rec_valid, 1);
      reset_n = 0;
      tick();
      reset_n = 1;
      check("rst_valid", rec_valid, 0);
      check("rst_overflow", overflow, 0);
      check("rst_drop", drop_cnt, 0);
      check("rst_halted", halted, 0);
      tick();
      check("rst_still_empty", rec_valid, 0);
      exp_drop = 0;

      // Trap then three WB events that must be ignored
      rec_ready = 1;
      trap_valid = 1; trap_pc = 32'h80; trap_instr = 32'h0000_0073;
      tick();
      trap_valid = 0;
      drive_wb(32'h90, 5'd8, 32'h9);
      check("trap_valid", rec_valid, 1);
      check("trap_type", rec_type, 3);
      check("trap_pc", rec_pc, 32'h80);
      check("trap_value", rec_value, 0);
      check("trap_halted", halted, 1);
      tick();
      check("halt_empty1", rec_valid, 0);
      tick();
      check("halt_empty2", rec_valid, 0);
      tick();
      clear_events();
      check("halt_empty3", rec_valid, 0);
      check("halt_drop", drop_cnt, 32'(exp_drop));
      check("halt_sticky", halted, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Retirement-side trace capture for the 5-stage RV32I core. Samples up to four commit events per cycle (register writeback, store, taken branch/jalr, trap) directly from the pipeline's MEM/WB, EX/MEM and redirect signals. Serializes them in a fixed order into a FIFO of uniform trace records. Presents the records on a valid/ready stream to the golden-trace checker or a debug UART, so the core runs at full speed while trace is consumed at any rate.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 4.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset.
- wb_valid  in  1  register writeback retires this cycle; core asserts only for rd != 0.
- wb_pc, wb_instr  in  32 each  PC and instruction of the writeback.
- wb_rd  in  5  destination register.
- wb_data  in  32  value written to rd, load results included.
- st_valid  in  1  store retires this cycle.
- st_pc, st_instr, st_addr, st_data  in  32 each  store PC, instruction, byte address and data.
- br_valid  in  1  taken branch or jalr redirect this cycle.
- br_pc, br_instr, br_target  in  32 each  branch PC, instruction and redirect target.
- trap_valid  in  1  ecall/ebreak reaches MEM/WB.
- trap_pc, trap_instr  in  32 each  trap PC and instruction.
- rec_valid  out  1  record available; equals (count != 0).
- rec_ready  in  1  consumer accepts the record.
- rec_type  out  2  record type: 0 REG, 1 STORE, 2 BR, 3 TRAP.
- rec_pc, rec_instr  out  32 each  record PC and instruction.
- rec_rd  out  5  wb_rd for REG records; 0 for other types.
- rec_addr  out  32  st_addr for STORE, br_target for BR; 0 for other types.
- rec_value  out  32  wb_data for REG, st_data for STORE; 0 for other types.
- halted  out  1  sticky; set when a trap record has been accepted.
- overflow  out  1  sticky; set when any event has been dropped.
- drop_cnt  out  DROP_W  saturating count of dropped events.

## Operation
- Storage is a circular FIFO with a register array, rd_ptr and wr_ptr of width log2(DEPTH), and count of width log2(DEPTH)+1.
- Pointers wrap modulo DEPTH.
- Event order within a cycle is fixed: WB, then STORE, then BR, then TRAP.
- Events present in a cycle are assigned consecutive slots starting at wr_ptr, in that order.
- free = DEPTH - count, evaluated at the start of the cycle. A pop in the same cycle does not create space for that cycle's pushes.
- The first min(events, free) events in order are written. The remaining events are dropped.
- Each dropped event increments drop_cnt, which saturates at all-ones, and sets overflow.
- A trap event that fits is written and sets halted the next cycle.
- A dropped trap sets neither halted nor anything else beyond the drop count.
- While halted = 1, all event inputs are ignored. Ignored events are not counted as drops. Draining continues normally.
- Pop occurs when rec_valid && rec_ready. rd_ptr advances and count = count + pushed - popped.
- Output fields are a combinational read of mem[rd_ptr] (show-ahead). They are held stable while rec_valid && !rec_ready.
- Unused fields of a record are stored as 0.

## Timing
- Reset values: rec_valid 0, all rec_* 0, halted 0, overflow 0, drop_cnt 0, pointers 0, count 0.
- Reset asserted mid-stream empties the FIFO on that edge. Undelivered records are lost.
- Latency: an event sampled at edge N is visible on rec_valid after edge N. A previously empty FIFO shows it in cycle N+1.
- Throughput: up to 4 pushes and 1 pop per cycle.
- Full FIFO with a simultaneous pop: all events that cycle are dropped, the pop completes, and count = DEPTH - 1.

## Configuration
- COMMIT_TRACE_BR_EN defined: BR events are captured as described.
- COMMIT_TRACE_BR_EN undefined:
  - br_valid, br_pc, br_instr and br_target are ignored.
  - Type 2 is never produced.
  - Ignored branches do not count as drops.
  - Event order becomes WB, STORE, TRAP.

## Test plan
- Single REG event, wb_pc=0x00000010, wb_rd=5, wb_data=0x1234 -> one cycle later rec_valid=1 with type 0, pc 0x10, rd 5, value 0x1234. With rec_ready=1 the FIFO is empty the following cycle.
- Same cycle: wb (pc 0x20), st (pc 0x24, addr 0x100, data 0xAB) and br (pc 0x28, target 0x40), consumer always ready -> three records in order REG, STORE, BR on consecutive cycles.
- rec_ready held 0 while 16 single events are pushed, then one more cycle with wb+st -> count 16, overflow=1, drop_cnt=2. The head record stays unchanged throughout.
- Count 15 with wb+st+br in one cycle -> only the WB record is stored, drop_cnt increases by 2, and count reaches 16.
- trap_valid at pc 0x80, then wb_valid on the next 3 cycles -> TRAP record delivered, halted=1, no further records, drop_cnt unchanged.
- Reset asserted while count=7 and rec_valid=1 -> next cycle rec_valid=0, count=0, and overflow, halted and drop_cnt all cleared.
